pulse_period_meter: RTL and testbench

Measures the interval, in `clk` cycles, between consecutive rising edges of a single-bit pulse input and reports each result with a one-cycle valid strobe. It is the receiving counterpart of the team's clock dividers: a divider's tick output fed into this block reads back the division ratio. The block is used for self-check of divider outputs and for measuring external periodic signals. Overflow and stability are flagged for downstream status logic.

---
 rtl/pulse_period_meter.sv | 177 +++++++++++++++++
 tb/tb_pulse_period_meter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_period_meter.sv
// Measures the clk-cycle interval between consecutive rising edges of pulse_in.
// Each result is strobed once; overflow and period-to-period stability are flagged.
module pulse_period_meter #(
    parameter int CNT_W = 16,
    parameter int TOL   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             overflow,
    output logic             stable
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W:0]   TOL_V    = (CNT_W+1)'(TOL);

    state_e           state_q, state_d;
    logic             s1_q, s2_q, s3_q;
    logic             rise_s;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] prev_q, prev_d;
    logic             valid_q, valid_d;
    logic             overflow_q, overflow_d;
    logic             stable_q, stable_d;
    logic             first_q, first_d;
    logic [CNT_W:0]   diff_s;
    logic [CNT_W:0]   mag_s;

    assign rise_s = s2_q & ~s3_q;

    // Two-flop synchronizer plus history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= pulse_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; dropping enable forces IDLE from any state.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_ARM;
                ST_ARM:  state_d = rise_s ? ST_MEAS : ST_ARM;
                ST_MEAS: begin
                    if (!rise_s && (cnt_q == CNT_MAX)) begin
                        state_d = ST_ARM;
                    end else begin
                        state_d = ST_MEAS;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Magnitude of (cnt - prev) in one extra bit so the borrow is visible.
    always_comb begin
        diff_s = {1'b0, cnt_q} - {1'b0, prev_q};
        if (diff_s[CNT_W]) begin
            mag_s = ~diff_s + {{CNT_W{1'b0}}, 1'b1};
        end else begin
            mag_s = diff_s;
        end
    end

    // Datapath next-state: counter, result, flags.
    always_comb begin
        cnt_d      = cnt_q;
        period_d   = period_q;
        prev_d     = prev_q;
        valid_d    = 1'b0;
        overflow_d = overflow_q;
        stable_d   = stable_q;
        first_d    = first_q;
        if (!enable) begin
            cnt_d    = CNT_ZERO;
            stable_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d    = CNT_ZERO;
                    stable_d = 1'b0;
                end
                ST_ARM: begin
                    if (rise_s) begin
                        cnt_d   = CNT_ONE;
                        first_d = 1'b1;
                    end else begin
                        cnt_d = CNT_ZERO;
                    end
                end
                ST_MEAS: begin
                    if (rise_s) begin
                        period_d   = cnt_q;
                        prev_d     = cnt_q;
                        valid_d    = 1'b1;
                        cnt_d      = CNT_ONE;
                        overflow_d = 1'b0;
                        first_d    = 1'b0;
                        if (!first_q) begin
                            stable_d = (mag_s <= TOL_V);
                        end else begin
                            stable_d = stable_q;
                        end
                    end else if (cnt_q == CNT_MAX) begin
                        overflow_d = 1'b1;
                        stable_d   = 1'b0;
                        cnt_d      = CNT_ZERO;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    cnt_d    = CNT_ZERO;
                    stable_d = 1'b0;
                end
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= CNT_ZERO;
            period_q   <= CNT_ZERO;
            prev_q     <= CNT_ZERO;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            stable_q   <= 1'b0;
            first_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            prev_q     <= prev_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            stable_q   <= stable_d;
            first_q    <= first_d;
        end
    end

    assign period       = period_q;
    assign period_valid = valid_q;
    assign overflow     = overflow_q;
    assign stable       = stable_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter: three instances (16-bit TOL=0, 16-bit TOL=1,
// 8-bit TOL=0) share one stimulus stream; each scenario checks the relevant instance.
module tb_pulse_period_meter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic pulse_in = 1'b0;

    logic [15:0] pa, pb;
    logic [7:0]  pc;
    logic va, vb, vc, oa, ob, oc, sa, sb, sc;

    int n_checks = 0;
    int n_fail = 0;
    int edge_cnt = 0;

    pulse_period_meter #(.CNT_W(16), .TOL(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pulse_in(pulse_in),
        .period(pa), .period_valid(va), .overflow(oa), .stable(sa));
    pulse_period_meter #(.CNT_W(16), .TOL(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pulse_in(pulse_in),
        .period(pb), .period_valid(vb), .overflow(ob), .stable(sb));
    pulse_period_meter #(.CNT_W(8), .TOL(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pulse_in(pulse_in),
        .period(pc), .period_valid(vc), .overflow(oc), .stable(sc));

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Strobe logs per instance, sampled on the falling edge.
    int na = 0, nb = 0, nc = 0;
    logic [15:0] per_a[64], per_b[64], per_c[64];
    logic        st_a[64], st_b[64], st_c[64];
    int          edg_a[64];
    int          ov_edge_c = -1;
    logic        oc_prev = 1'b0;

    always @(negedge clk) begin
        if (va === 1'b1 && na < 64) begin
            per_a[na] = pa; st_a[na] = sa; edg_a[na] = edge_cnt; na++;
        end
        if (vb === 1'b1 && nb < 64) begin
            per_b[nb] = pb; st_b[nb] = sb; nb++;
        end
        if (vc === 1'b1 && nc < 64) begin
            per_c[nc] = {8'd0, pc}; st_c[nc] = sc; nc++;
        end
        if (oc === 1'b1 && oc_prev !== 1'b1) ov_edge_c = edge_cnt;
        oc_prev = oc;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Pulse sampled high at the next edge; returns that edge number, then idles gap-1 edges.
    task automatic pulse(input int gap, output int e);
        pulse_in = 1'b1;
        tick();
        e = edge_cnt;
        pulse_in = 1'b0;
        ticks(gap - 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        pulse_in = 1'b0;
        ticks(2);
        rst_n = 1'b1;
        ticks(1);
    endtask

    task automatic start();
        enable = 1'b1;
        ticks(3);
    endtask

    int e, e1, e0, base, base_b;

    initial begin
        // Reset state
        do_reset();
        chk("rst_period_a", pa, 0);
        chk("rst_valid_a", va, 0);
        chk("rst_ovf_a", oa, 0);
        chk("rst_stable_a", sa, 0);
        chk("rst_period_b", pb, 0);
        chk("rst_flags_b", {vb, ob, sb}, 0);
        chk("rst_period_c", pc, 0);
        chk("rst_flags_c", {vc, oc, sc}, 0);

        // Divider tick, 240-cycle period, 5 pulses
        start();
        base = na;
        e1 = 0;
        for (int i = 0; i < 5; i++) begin
            pulse(240, e);
            if (i == 1) e1 = e;
        end
        chk("div_strobes", na - base, 4);
        for (int i = 0; i < 4; i++) begin
            chk("div_period", per_a[base+i], 240);
            chk("div_stable", st_a[base+i], (i == 0) ? 0 : 1);
        end
        chk("div_latency", edg_a[base], e1 + 2);
        chk("div_ovf", oa, 0);
        enable = 1'b0;
        tick();
        chk("dis_stable_clr", sa, 0);
        chk("dis_period_hold", pa, 240);

        // Jitter 100/102/101
        do_reset();
        start();
        base = na;
        base_b = nb;
        pulse(100, e);
        pulse(102, e);
        pulse(101, e);
        pulse(20, e);
        chk("jit_strobes", nb - base_b, 3);
        chk("jit_p0", per_b[base_b], 100);
        chk("jit_p1", per_b[base_b+1], 102);
        chk("jit_p2", per_b[base_b+2], 101);
        chk("jit_s0", st_b[base_b], 0);
        chk("jit_s1", st_b[base_b+1], 0);
        chk("jit_s2", st_b[base_b+2], 1);
        chk("jit_tol0_s2", st_a[base+2], 0);

        // Overflow on the 8-bit instance
        do_reset();
        start();
        base = nc;
        pulse(300, e0);
        chk("ovf_edge", ov_edge_c, e0 + 257);
        chk("ovf_flag", oc, 1);
        chk("ovf_no_strobe", nc - base, 0);
        chk("ovf_period_hold", pc, 0);
        pulse(50, e);
        pulse(10, e);
        chk("ovf_rearm_strobes", nc - base, 1);
        chk("ovf_rearm_period", per_c[base], 50);
        chk("ovf_cleared", oc, 0);

        // Saturation coinciding with an edge
        do_reset();
        start();
        base = nc;
        pulse(255, e);
        pulse(255, e);
        pulse(255, e);
        pulse(10, e);
        chk("sat_strobes", nc - base, 3);
        for (int i = 0; i < 3; i++) begin
            chk("sat_period", per_c[base+i], 255);
        end
        chk("sat_stable", st_c[base+2], 1);
        chk("sat_ovf", oc, 0);

        // Disable 30 cycles into a 200-cycle interval
        do_reset();
        start();
        base = na;
        pulse(150, e);
        pulse(30, e);
        enable = 1'b0;
        ticks(5);
        enable = 1'b1;
        ticks(164);
        pulse(200, e);
        chk("abort_no_strobe", na - base, 1);
        chk("abort_period_hold", pa, 150);
        pulse(200, e);
        pulse(20, e);
        chk("abort_strobes", na - base, 3);
        chk("abort_p1", per_a[base+1], 200);
        chk("abort_s1", st_a[base+1], 0);
        chk("abort_p2", per_a[base+2], 200);
        chk("abort_s2", st_a[base+2], 1);

        // Asynchronous reset between edges while measuring
        do_reset();
        start();
        pulse(20, e);
        pulse(20, e);
        pulse(20, e);
        chk("pre_rst_period", pa, 20);
        chk("pre_rst_stable", sa, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_period", pa, 0);
        chk("arst_flags", {va, oa, sa}, 0);
        #3;
        rst_n = 1'b1;
        tick();
        base = na;
        pulse(10, e);
        pulse(10, e);
        pulse(10, e);
        ticks(5);
        chk("post_rst_strobes", na - base, 2);
        chk("post_rst_p0", per_a[base], 10);
        chk("post_rst_p1", per_a[base+1], 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
